// File: rtl/regfile_mp_sb_pkg.sv
// Shared defaults and the reset image for the two-write/two-read register file.
package rf_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned NREG   = 2 ** ADDR_W;

    // Index-seeded image keeps the low registers distinguishable after reset.
    function automatic logic [31:0] rf_init_val(input int unsigned idx, input bit initIndex);
        return (initIndex && idx < 8) ? idx : '0;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Read, write, issue and status signals of the register file, grouped per side.
interface regfile_mp_sb_if #(
    parameter int unsigned DATA_W = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic [DATA_W-1:0] r_last;
    logic              we1;
    logic [ADDR_W-1:0] waddr1;
    logic [DATA_W-1:0] wdata1;
    logic              we2;
    logic [ADDR_W-1:0] waddr2;
    logic [DATA_W-1:0] wdata2;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_addr;
    logic              wr_conflict;

    modport slave (
        input  rd_addr1, rd_addr2, we1, waddr1, wdata1, we2, waddr2, wdata2, iss_valid, iss_addr,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, r_last, wr_conflict
    );

    modport master (
        output rd_addr1, rd_addr2, we1, waddr1, wdata1, we2, waddr2, wdata2, iss_valid, iss_addr,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, r_last, wr_conflict
    );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, issue wins on a same-cycle collision.
module rf_scoreboard #(
    parameter int unsigned ADDR_W = rf_pkg::ADDR_W,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic              we2,
    input  logic [ADDR_W-1:0] waddr2,
    input  logic              issValid,
    input  logic [ADDR_W-1:0] issAddr,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    output logic              rdBusy1,
    output logic              rdBusy2
);
    localparam int unsigned NREG = 2 ** ADDR_W;

    logic [NREG-1:0] busy;
    logic            hit1;
    logic            hit2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (issValid && issAddr == ADDR_W'(i))
                    busy[i] <= 1'b1;
                else if ((we1 && waddr1 == ADDR_W'(i)) || (we2 && waddr2 == ADDR_W'(i)))
                    busy[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        hit1    = (we1 && waddr1 == rdAddr1) || (we2 && waddr2 == rdAddr1);
        hit2    = (we1 && waddr1 == rdAddr2) || (we2 && waddr2 == rdAddr2);
        rdBusy1 = busy[rdAddr1] && !(BYPASS && hit1);
        rdBusy2 = busy[rdAddr2] && !(BYPASS && hit2);
    end
endmodule

// File: rtl/regfile_mp_sb.sv
// Two-write/two-read register file with write bypass, optional zero register and busy scoreboard.
module regfile_mp_sb
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W     = rf_pkg::DATA_W,
    parameter int unsigned ADDR_W     = rf_pkg::ADDR_W,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          ZERO_REG   = 1'b0,
    parameter bit          INIT_INDEX = 1'b1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_sb_if.slave bus
);
    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              w1Eff;
    logic              w2Eff;
    logic              issEff;
    logic              conflictQ;

    // Writes and issues to R0 are squashed here so storage and scoreboard never see them.
    always_comb begin
        w1Eff  = bus.we1 && !(ZERO_REG && bus.waddr1 == '0);
        w2Eff  = bus.we2 && !(ZERO_REG && bus.waddr2 == '0);
        issEff = bus.iss_valid && !(ZERO_REG && bus.iss_addr == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++)
                regs[i] <= DATA_W'(rf_init_val(i, INIT_INDEX));
            conflictQ <= 1'b0;
        end else begin
            if (w1Eff) regs[bus.waddr1] <= bus.wdata1;
            if (w2Eff) regs[bus.waddr2] <= bus.wdata2;
            conflictQ <= bus.we1 && bus.we2 && bus.waddr1 == bus.waddr2;
        end
    end

    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs[addr];
        if (BYPASS && w1Eff && bus.waddr1 == addr) val = bus.wdata1;
        if (BYPASS && w2Eff && bus.waddr2 == addr) val = bus.wdata2;
        if (ZERO_REG && addr == '0) val = '0;
        return val;
    endfunction

    always_comb begin
        bus.rd_data1    = readPort(bus.rd_addr1);
        bus.rd_data2    = readPort(bus.rd_addr2);
        bus.r_last      = regs[NREGS-1];
        bus.wr_conflict = conflictQ;
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) uScoreboard (
        .clk      (clk),
        .rst      (rst),
        .we1      (w1Eff),
        .waddr1   (bus.waddr1),
        .we2      (w2Eff),
        .waddr2   (bus.waddr2),
        .issValid (issEff),
        .issAddr  (bus.iss_addr),
        .rdAddr1  (bus.rd_addr1),
        .rdAddr2  (bus.rd_addr2),
        .rdBusy1  (bus.rd_busy1),
        .rdBusy2  (bus.rd_busy2)
    );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench: two configurations driven in lockstep against a register-array reference model.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(4)) ifA ();
    regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(4)) ifB ();

    regfile_mp_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b1), .ZERO_REG(1'b0), .INIT_INDEX(1'b1))
        dutA (.clk(clk), .rst(rst), .bus(ifA));
    regfile_mp_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1'b0), .ZERO_REG(1'b1), .INIT_INDEX(1'b1))
        dutB (.clk(clk), .rst(rst), .bus(ifB));

    typedef struct packed {
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] rl;
        logic        b1;
        logic        b2;
        logic        wc;
    } exp_t;

    exp_t expQ[2][$];
    event sampled;
    int   checks = 0;
    int   errors = 0;

    bit          pBypass[2] = '{1'b1, 1'b0};
    bit          pZero[2]   = '{1'b0, 1'b1};
    logic [15:0] mReg[2][16];
    bit          mBusy[2][16];
    bit          mConf[2];

    task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %h want %h", name, k, $time, act, exp);
        end
    endtask

    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) begin
                mReg[k][i]  = (i < 8) ? 16'(i) : 16'h0;
                mBusy[k][i] = 1'b0;
            end
            mConf[k] = 1'b0;
        end
    endfunction

    task automatic step(input bit r, input bit w1, input logic [3:0] a1, input logic [15:0] v1,
                        input bit w2, input logic [3:0] a2, input logic [15:0] v2,
                        input bit iv, input logic [3:0] ia, input logic [3:0] ra1, input logic [3:0] ra2);
        exp_t e;
        bit   e1, e2, ei;
        @(negedge clk);
        rst = r;
        ifA.we1 = w1; ifA.waddr1 = a1; ifA.wdata1 = v1; ifA.we2 = w2; ifA.waddr2 = a2; ifA.wdata2 = v2;
        ifA.iss_valid = iv; ifA.iss_addr = ia; ifA.rd_addr1 = ra1; ifA.rd_addr2 = ra2;
        ifB.we1 = w1; ifB.waddr1 = a1; ifB.wdata1 = v1; ifB.we2 = w2; ifB.waddr2 = a2; ifB.wdata2 = v2;
        ifB.iss_valid = iv; ifB.iss_addr = ia; ifB.rd_addr1 = ra1; ifB.rd_addr2 = ra2;
        #1;
        for (int k = 0; k < 2; k++) begin
            e1 = w1 && !(pZero[k] && a1 == 0);
            e2 = w2 && !(pZero[k] && a2 == 0);
            ei = iv && !(pZero[k] && ia == 0);
            e.d1 = mReg[k][ra1];
            e.d2 = mReg[k][ra2];
            e.b1 = mBusy[k][ra1];
            e.b2 = mBusy[k][ra2];
            if (pBypass[k]) begin
                if (e2 && a2 == ra1) e.d1 = v2; else if (e1 && a1 == ra1) e.d1 = v1;
                if (e2 && a2 == ra2) e.d2 = v2; else if (e1 && a1 == ra2) e.d2 = v1;
                if ((e1 && a1 == ra1) || (e2 && a2 == ra1)) e.b1 = 1'b0;
                if ((e1 && a1 == ra2) || (e2 && a2 == ra2)) e.b2 = 1'b0;
            end
            if (pZero[k] && ra1 == 0) begin e.d1 = '0; e.b1 = 1'b0; end
            if (pZero[k] && ra2 == 0) begin e.d2 = '0; e.b2 = 1'b0; end
            e.rl = mReg[k][15];
            e.wc = mConf[k];
            expQ[k].push_back(e);
        end
        -> sampled;
        if (!r) begin
            modelReset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                e1 = w1 && !(pZero[k] && a1 == 0);
                e2 = w2 && !(pZero[k] && a2 == 0);
                ei = iv && !(pZero[k] && ia == 0);
                if (e1) begin mReg[k][a1] = v1; mBusy[k][a1] = 1'b0; end
                if (e2) begin mReg[k][a2] = v2; mBusy[k][a2] = 1'b0; end
                if (ei) mBusy[k][ia] = 1'b1;
                mConf[k] = w1 && w2 && a1 == a2;
            end
        end
    endtask

    task automatic idle(input logic [3:0] ra1, input logic [3:0] ra2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ra1, ra2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(sampled);
            e = expQ[0].pop_front();
            chk("rd_data1", 0, ifA.rd_data1, e.d1);
            chk("rd_data2", 0, ifA.rd_data2, e.d2);
            chk("rd_busy1", 0, 16'(ifA.rd_busy1), 16'(e.b1));
            chk("rd_busy2", 0, 16'(ifA.rd_busy2), 16'(e.b2));
            chk("r_last", 0, ifA.r_last, e.rl);
            chk("wr_conflict", 0, 16'(ifA.wr_conflict), 16'(e.wc));
            e = expQ[1].pop_front();
            chk("rd_data1", 1, ifB.rd_data1, e.d1);
            chk("rd_data2", 1, ifB.rd_data2, e.d2);
            chk("rd_busy1", 1, 16'(ifB.rd_busy1), 16'(e.b1));
            chk("rd_busy2", 1, 16'(ifB.rd_busy2), 16'(e.b2));
            chk("r_last", 1, ifB.r_last, e.rl);
            chk("wr_conflict", 1, 16'(ifB.wr_conflict), 16'(e.wc));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [3:0] a1, a2, ia;
        bit         iv;
        modelReset();
        // Reset held two cycles with a write pending: the write must be dropped.
        step(0, 1, 3, 16'hFFFF, 0, 0, 0, 0, 0, 3, 15);
        step(0, 1, 3, 16'hFFFF, 0, 0, 0, 0, 0, 3, 15);
        idle(3, 15);
        step(1, 1, 5, 16'hAAAA, 1, 9, 16'h5555, 0, 0, 5, 9);
        idle(5, 9);
        step(1, 1, 4, 16'h1111, 1, 4, 16'h2222, 0, 0, 4, 1);
        idle(4, 1);
        idle(4, 1);
        step(1, 1, 6, 16'hBEEF, 0, 0, 0, 0, 0, 2, 6);
        idle(2, 6);
        step(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 6);
        idle(7, 6);
        step(1, 1, 7, 16'h7777, 0, 0, 0, 0, 0, 7, 6);
        idle(7, 6);
        step(1, 0, 0, 0, 1, 7, 16'h7A7A, 1, 7, 7, 7);
        idle(7, 7);
        step(1, 1, 7, 16'h0707, 0, 0, 0, 0, 0, 7, 7);
        step(1, 1, 0, 16'h1234, 0, 0, 0, 1, 0, 0, 7);
        idle(0, 7);
        step(1, 0, 0, 0, 1, 0, 16'h0000, 0, 0, 0, 7);
        step(1, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
        idle(2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        idle(2, 0);
        for (int n = 0; n < 600; n++) begin
            a1 = 4'($urandom_range(15));
            a2 = ($urandom_range(3) == 0) ? a1 : 4'($urandom_range(15));
            ia = 4'($urandom_range(15));
            // A second writer to a busy register is undefined; keep the stimulus legal.
            iv = ($urandom_range(2) == 0) && !mBusy[0][ia] && !mBusy[1][ia];
            step(($urandom_range(63) != 0),
                 $urandom_range(1) == 1, a1, 16'($urandom),
                 $urandom_range(1) == 1, a2, 16'($urandom),
                 iv, ia, 4'($urandom_range(15)), ($urandom_range(3) == 0) ? a1 : 4'($urandom_range(15)));
        end
        idle(0, 15);
        @(negedge clk);
        checks++;
        if (expQ[0].size() != 0 || expQ[1].size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d/%0d want 0/0", expQ[0].size(), expQ[1].size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
